// File: rtl/pipe_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_seq_pkg
//  Description : Shared types and constants for the staggered pipe-start
//                sequencer (state encoding, standard start intervals).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_seq_pkg;

    // Sequencer states: armed, counting an interval, all channels started
    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2
    } seq_state_e;

    // Interval presets at a 148.5 MHz pixel clock
    localparam int PIPE_INTERVAL_1S = 148_500_000;
    localparam int PIPE_INTERVAL_2S = 297_000_000;

endpackage : pipe_seq_pkg
`default_nettype wire

// File: rtl/pipe_start_seq_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module      : interval_timer
//  Description : Free-running interval counter for the pipe-start sequencer.
//                Counts enabled cycles 0..INTERVAL-1 and raises tick on the
//                enabled cycle that closes an interval, then wraps to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module interval_timer #(
    parameter int INTERVAL = 4,
    parameter int CNT_W    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(INTERVAL - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign tick = en && (cnt_q == c_last);

    // Next count: clear has priority, otherwise advance and wrap on tick
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : interval_timer
`default_nettype wire

// File: rtl/pipe_start_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_start_seq
//  Description : Staggered-start sequencer for the pipe generators. Raises
//                NUM_CH sticky start flags INTERVAL enabled cycles apart,
//                with pause (en), restart, per-channel pulses and done.
//                Optional feature macro: PIPE_SEQ_PULSE_EN (start_pulse
//                registers built when defined, port tied low otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_start_seq
    import pipe_seq_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int INTERVAL = PIPE_INTERVAL_1S,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    output logic [NUM_CH-1:0] start,
    output logic [NUM_CH-1:0] start_pulse,
    output logic              done
);

    localparam int                IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] c_one      = NUM_CH'(1);

    seq_state_e        state_d, state_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic [NUM_CH-1:0] start_d, start_q;
    logic              done_d, done_q;

    logic [IDX_W-1:0]  w_next_idx;
    logic              w_timer_en;
    logic              w_tick;

    // The timer only runs while an interval is pending; a restart takes
    // precedence over en and clears it in the same cycle.
    assign w_timer_en = en && !restart && (state_q == S_WAIT);
    assign w_next_idx = idx_q + 1'b1;

    interval_timer #(
        .INTERVAL (INTERVAL),
        .CNT_W    (CNT_W)
    ) u_interval_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .en   (w_timer_en),
        .tick (w_tick)
    );

    // Next-state and flag update: restart beats en; S_DONE holds everything
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        start_d = start_q;
        done_d  = done_q;
        if (restart) begin
            state_d = S_FIRST;
            idx_d   = '0;
            start_d = '0;
            done_d  = 1'b0;
        end else if (en) begin
            case (state_q)
                S_FIRST: begin
                    start_d = start_q | c_one;
                    idx_d   = '0;
                    if (NUM_CH == 1) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_tick) begin
                        idx_d   = w_next_idx;
                        start_d = start_q | (c_one << w_next_idx);
                        if (w_next_idx == c_last_idx) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_FIRST;
                end
            endcase
        end
    end

    // State, index and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FIRST;
            idx_q   <= '0;
            start_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign start = start_q;
    assign done  = done_q;

`ifdef PIPE_SEQ_PULSE_EN
    logic [NUM_CH-1:0] pulse_d, pulse_q;

    // A pulse marks each flag's rising edge; it self-clears next cycle
    always_comb begin
        pulse_d = start_d & ~start_q;
    end

    // Pulse register, cleared by reset and never held by en
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign start_pulse = pulse_q;
`else
    assign start_pulse = '0;
`endif

endmodule : pipe_start_seq
`default_nettype wire

// File: tb/tb_pipe_start_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_start_seq
//  Description : Self-checking bench for pipe_start_seq. Two instances share
//                stimulus: NUM_CH=3/INTERVAL=4 and NUM_CH=1/INTERVAL=1.
//                Expected outputs come from an enabled-edge count model and
//                are queued per cycle, then popped after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_start_seq;

    logic       clk;
    logic       rst;
    logic       en;
    logic       restart;
    logic [2:0] start3, pulse3;
    logic       done3;
    logic [0:0] start1, pulse1;
    logic       done1;

    typedef struct {
        logic [2:0] s3;
        logic [2:0] p3;
        logic       d3;
        logic       s1;
        logic       p1;
        logic       d1;
    } exp_t;

    exp_t sb[$];

    int         n_checks;
    int         n_bad;
    int         cnt3;
    int         cnt1;
    logic [2:0] prev3;
    logic       prev1;

    pipe_start_seq #(.NUM_CH(3), .INTERVAL(4), .CNT_W(8)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .restart     (restart),
        .start       (start3),
        .start_pulse (pulse3),
        .done        (done3)
    );

    pipe_start_seq #(.NUM_CH(1), .INTERVAL(1), .CNT_W(4)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .restart     (restart),
        .start       (start1),
        .start_pulse (pulse1),
        .done        (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Channel k is started once the count of enabled edges exceeds k*interval
    function automatic logic [7:0] model_start(input int n, input int ch, input int interval);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < ch; k++) begin
            if (n >= k * interval + 1) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Drive one cycle of stimulus, queue the expectation, then compare
    task automatic step(input logic r, input logic rs, input logic e);
        exp_t       x;
        exp_t       y;
        logic [7:0] m;
        rst     = r;
        restart = rs;
        en      = e;
        if (r || rs) begin
            cnt3 = 0;
            cnt1 = 0;
        end else if (e) begin
            cnt3++;
            cnt1++;
        end
        m    = model_start(cnt3, 3, 4);
        x.s3 = m[2:0];
        m    = model_start(cnt1, 1, 1);
        x.s1 = m[0];
        x.d3 = x.s3[2];
        x.d1 = x.s1;
`ifdef PIPE_SEQ_PULSE_EN
        x.p3 = x.s3 & ~prev3;
        x.p1 = x.s1 & ~prev1;
`else
        x.p3 = 3'b000;
        x.p1 = 1'b0;
`endif
        prev3 = x.s3;
        prev1 = x.s1;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            y = sb.pop_front();
            check("start3", {5'd0, start3}, {5'd0, y.s3});
            check("pulse3", {5'd0, pulse3}, {5'd0, y.p3});
            check("done3",  {7'd0, done3},  {7'd0, y.d3});
            check("start1", {7'd0, start1}, {7'd0, y.s1});
            check("pulse1", {7'd0, pulse1}, {7'd0, y.p1});
            check("done1",  {7'd0, done1},  {7'd0, y.d1});
        end
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        cnt3     = 0;
        cnt1     = 0;
        prev3    = '0;
        prev1    = 1'b0;
        rst      = 1'b1;
        restart  = 1'b0;
        en       = 1'b0;

        // Reset state, held with en high to prove rst dominates
        step(1, 0, 0);
        step(1, 0, 1);

        // Continuous enable: 001 after E0, 011 after E4, 111 after E8
        for (int i = 0; i < 12; i++) step(0, 0, 1);

        // Pause of 5 cycles between E2 and E3
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1);

        // Restart after E5 with en high in the same cycle
        step(0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1);
        step(0, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1);

        // Restart together with en while in S_DONE, then hold off
        step(0, 1, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);

        // Restart on the cycle a pulse is visible (after E4)
        step(0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        step(0, 1, 0);
        step(0, 0, 1);

        // Synchronous reset after E6, then re-release
        step(0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1);
        step(1, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1);

        // Random pauses and occasional restarts
        for (int i = 0; i < 60; i++) begin
            step(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
        end

        if (sb.size() != 0) check("scoreboard_leftover", 8'(sb.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule : tb_pipe_start_seq
`default_nettype wire
